ram_1r1w_fast: RTL and testbench

Parametrised one-write-port / one-read-port RAM for the cmpe220 memory tests, successor to the fixed 16x256 single-port forwarding RAM wrapper.
- Generalises width and depth; adds byte-enable writes and a selectable write-to-read forward mode.
- Adds a 2-deep credit-managed read-ack queue so `ack_retry` backpressure never loses data.
- Adds a post-reset zero-initialisation sweep.
- All channels use the team's valid/retry handshake. A transfer fires when valid=1 and retry=0 in the same cycle.

---
 rtl/ram_1r1w_fast.sv | 98 +++++++++
 tb/tb_ram_1r1w_fast.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1r1w_fast.sv
// One-write / one-read RAM with byte enables, optional write-to-read forwarding,
// a post-reset zeroing sweep and a 2-deep credit-managed read response queue.
module ram_1r1w_fast #(
  parameter int Width   = 16,
  parameter int Size    = 256,
  parameter int Forward = 1,
  localparam int AW = $clog2(Size),
  localparam int NB = Width / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_retry,
  input  logic [AW-1:0]    wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic [NB-1:0]    wr_be,
  input  logic             rd_valid,
  output logic             rd_retry,
  input  logic [AW-1:0]    rd_addr,
  output logic             ack_valid,
  input  logic             ack_retry,
  output logic [Width-1:0] ack_data
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [AW-1:0] LastAddr = AW'(Size - 1);

  state_t           state, state_next;
  logic [AW-1:0]    ic;
  logic [Width-1:0] mem [Size];

  logic             wr_fire, rd_fire, ack_fire;
  logic [Width-1:0] wr_merged, rd_word;

  logic [Width-1:0] q_data [2];
  logic             q_head, q_tail;
  logic [1:0]       occ;

  // Both retries come from registered state only; ack_retry never reaches them.
  assign wr_retry  = (state == S_INIT);
  assign rd_retry  = (state == S_INIT) || (occ == 2'd2);
  assign wr_fire   = wr_valid && !wr_retry;
  assign rd_fire   = rd_valid && !rd_retry;
  assign ack_valid = (occ != 2'd0);
  assign ack_fire  = ack_valid && !ack_retry;
  assign ack_data  = q_data[q_head];

  always_comb begin
    state_next = state;
    if (state == S_INIT && ic == LastAddr) state_next = S_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
      ic    <= '0;
    end else begin
      state <= state_next;
      if (state == S_INIT) ic <= ic + 1'b1;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_merged = mem[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
    rd_word = mem[rd_addr];
    if (Forward != 0 && wr_fire && wr_addr == rd_addr) rd_word = wr_merged;
  end

  // NOTE: the array has no reset; the INIT sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == S_INIT) mem[ic] <= '0;
    else if (wr_fire)    mem[wr_addr] <= wr_merged;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_data[0] <= '0;
      q_data[1] <= '0;
      q_head    <= 1'b0;
      q_tail    <= 1'b0;
      occ       <= 2'd0;
    end else begin
      if (rd_fire) begin
        q_data[q_tail] <= rd_word;
        q_tail         <= ~q_tail;
      end
      if (ack_fire) q_head <= ~q_head;
      occ <= occ + 2'(rd_fire) - 2'(ack_fire);
    end
  end

endmodule

// File: tb/tb_ram_1r1w_fast.sv
// Directed bench for ram_1r1w_fast: one instance per forwarding mode, same stimulus.
module tb_ram_1r1w_fast;

  localparam int Width = 16;
  localparam int Size  = 256;
  localparam int AW    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_valid, rd_valid, ack_retry;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [Width-1:0] wr_data;
  logic [1:0]       wr_be;

  logic             f_wr_retry, f_rd_retry, f_ack_valid;
  logic [Width-1:0] f_ack_data;
  logic             o_wr_retry, o_rd_retry, o_ack_valid;
  logic [Width-1:0] o_ack_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_1r1w_fast #(.Width(Width), .Size(Size), .Forward(1)) u_fwd (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_retry(f_wr_retry), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_retry(f_rd_retry), .rd_addr(rd_addr),
    .ack_valid(f_ack_valid), .ack_retry(ack_retry), .ack_data(f_ack_data)
  );

  ram_1r1w_fast #(.Width(Width), .Size(Size), .Forward(0)) u_old (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_retry(o_wr_retry), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_retry(o_rd_retry), .rd_addr(rd_addr),
    .ack_valid(o_ack_valid), .ack_retry(ack_retry), .ack_data(o_ack_data)
  );

  // Stimulus helpers: called at a negedge, they return at a later negedge.
  task automatic write_word(input logic [AW-1:0] a, input logic [Width-1:0] d, input logic [1:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [Width-1:0] fd,
                           output logic [Width-1:0] od, output logic ok);
    rd_valid = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_valid = 1'b0;
    fd = f_ack_data; od = o_ack_data;
    ok = f_ack_valid && o_ack_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; ack_retry = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    #3;
    checks++;
    if ({f_ack_valid, f_rd_retry, f_wr_retry, o_ack_valid, o_rd_retry, o_wr_retry} !== 6'b011011) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=011011",
               {f_ack_valid, f_rd_retry, f_wr_retry, o_ack_valid, o_rd_retry, o_wr_retry});
    end
    checks++;
    if (f_ack_data !== 16'h0000) begin failures++; $display("FAIL reset_ack_data got=%h exp=0000", f_ack_data); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_init_sweep;
    int bad = 0;
    reset = 1'b0;
    rd_valid = 1'b1; rd_addr = 8'h05;
    for (int i = 0; i < Size; i++) begin
      if (!(f_rd_retry && f_wr_retry && o_rd_retry && !f_ack_valid)) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL init_retry_high bad_cycles=%0d exp=0", bad); end
    checks++;
    if ({f_rd_retry, f_wr_retry} !== 2'b00) begin
      failures++; $display("FAIL init_release_256 got=%b exp=00", {f_rd_retry, f_wr_retry});
    end
    @(negedge clk);
    rd_valid = 1'b0;
    checks++;
    if (f_ack_valid !== 1'b1 || f_ack_data !== 16'h0000) begin
      failures++; $display("FAIL init_first_ack valid=%b data=%h exp=1/0000", f_ack_valid, f_ack_data);
    end
    @(negedge clk);
  endtask

  task automatic test_byte_enable;
    logic [Width-1:0] fd, od;
    logic ok;
    write_word(8'h12, 16'hAAAA, 2'b11);
    write_word(8'h12, 16'h5555, 2'b01);
    read_word(8'h12, fd, od, ok);
    checks++;
    if (!ok || fd !== 16'hAA55 || od !== 16'hAA55) begin
      failures++; $display("FAIL byte_enable ok=%b fwd=%h old=%h exp=AA55", ok, fd, od);
    end
    write_word(8'h12, 16'h0000, 2'b00);
    read_word(8'h12, fd, od, ok);
    checks++;
    if (!ok || fd !== 16'hAA55) begin failures++; $display("FAIL be_zero_noop ok=%b got=%h exp=AA55", ok, fd); end
  endtask

  task automatic test_forwarding;
    logic [Width-1:0] fd, od;
    logic ok;
    write_word(8'h20, 16'h1111, 2'b11);
    wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 16'hBEEF; wr_be = 2'b10;
    rd_valid = 1'b1; rd_addr = 8'h20;
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
    checks++;
    if (f_ack_valid !== 1'b1 || f_ack_data !== 16'hBE11) begin
      failures++; $display("FAIL forward_on got=%h exp=BE11", f_ack_data);
    end
    checks++;
    if (o_ack_valid !== 1'b1 || o_ack_data !== 16'h1111) begin
      failures++; $display("FAIL forward_off got=%h exp=1111", o_ack_data);
    end
    read_word(8'h20, fd, od, ok);
    checks++;
    if (!ok || fd !== 16'hBE11 || od !== 16'hBE11) begin
      failures++; $display("FAIL forward_after ok=%b fwd=%h old=%h exp=BE11", ok, fd, od);
    end
    // Write and read on different addresses in the same cycle
    wr_valid = 1'b1; wr_addr = 8'h21; wr_data = 16'h7777; wr_be = 2'b11;
    rd_valid = 1'b1; rd_addr = 8'h20;
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
    checks++;
    if (f_ack_data !== 16'hBE11 || o_ack_data !== 16'hBE11) begin
      failures++; $display("FAIL diff_addr fwd=%h old=%h exp=BE11", f_ack_data, o_ack_data);
    end
    read_word(8'h21, fd, od, ok);
    checks++;
    if (!ok || fd !== 16'h7777) begin failures++; $display("FAIL diff_addr_write got=%h exp=7777", fd); end
  endtask

  task automatic test_backpressure;
    write_word(8'h01, 16'h0001, 2'b11);
    write_word(8'h02, 16'h0002, 2'b11);
    write_word(8'h03, 16'h0003, 2'b11);
    @(negedge clk);
    ack_retry = 1'b1;
    rd_valid = 1'b1; rd_addr = 8'h01;
    checks++;
    if (f_rd_retry !== 1'b0) begin failures++; $display("FAIL bp_first_accept rd_retry=%b exp=0", f_rd_retry); end
    @(negedge clk);
    rd_addr = 8'h02;
    checks++;
    if (f_rd_retry !== 1'b0 || f_ack_valid !== 1'b1 || f_ack_data !== 16'h0001) begin
      failures++; $display("FAIL bp_second rd_retry=%b valid=%b data=%h exp=0/1/0001", f_rd_retry, f_ack_valid, f_ack_data);
    end
    @(negedge clk);
    rd_addr = 8'h03;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (f_rd_retry !== 1'b1 || f_ack_valid !== 1'b1 || f_ack_data !== 16'h0001) begin
        failures++; $display("FAIL bp_hold cyc=%0d rd_retry=%b valid=%b data=%h exp=1/1/0001", i, f_rd_retry, f_ack_valid, f_ack_data);
      end
      @(negedge clk);
    end
    ack_retry = 1'b0;
    checks++;
    if (f_ack_data !== 16'h0001) begin failures++; $display("FAIL bp_release_head got=%h exp=0001", f_ack_data); end
    @(negedge clk);
    checks++;
    if (f_rd_retry !== 1'b0 || f_ack_valid !== 1'b1 || f_ack_data !== 16'h0002) begin
      failures++; $display("FAIL bp_second_resp rd_retry=%b valid=%b data=%h exp=0/1/0002", f_rd_retry, f_ack_valid, f_ack_data);
    end
    @(negedge clk);
    rd_valid = 1'b0;
    checks++;
    if (f_ack_valid !== 1'b1 || f_ack_data !== 16'h0003) begin
      failures++; $display("FAIL bp_third_resp valid=%b data=%h exp=1/0003", f_ack_valid, f_ack_data);
    end
    @(negedge clk);
    checks++;
    if (f_ack_valid !== 1'b0) begin failures++; $display("FAIL bp_drained valid=%b exp=0", f_ack_valid); end
  endtask

  task automatic test_streaming;
    int bad_retry = 0;
    int bad_ack = 0;
    logic [7:0] k;
    for (int i = 0; i < 64; i++) begin
      k = 8'(i);
      write_word(k, {k ^ 8'h5A, k}, 2'b11);
    end
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) begin
        rd_valid = 1'b1; rd_addr = 8'(i);
        if (f_rd_retry !== 1'b0) bad_retry++;
      end else begin
        rd_valid = 1'b0;
      end
      if (i > 0) begin
        k = 8'(i - 1);
        if (f_ack_valid !== 1'b1 || f_ack_data !== {k ^ 8'h5A, k}) bad_ack++;
      end else if (f_ack_valid !== 1'b0) begin
        bad_ack++;
      end
      @(negedge clk);
    end
    checks++;
    if (bad_retry != 0) begin failures++; $display("FAIL stream_retry bad=%0d exp=0", bad_retry); end
    checks++;
    if (bad_ack != 0) begin failures++; $display("FAIL stream_acks bad=%0d exp=0", bad_ack); end
    checks++;
    if (f_ack_valid !== 1'b0) begin failures++; $display("FAIL stream_end valid=%b exp=0", f_ack_valid); end
  endtask

  task automatic test_mid_run_reset;
    int bad = 0;
    ack_retry = 1'b1;
    rd_valid = 1'b1; rd_addr = 8'h05;
    @(negedge clk);
    rd_addr = 8'h06;
    @(negedge clk);
    rd_valid = 1'b0;
    checks++;
    if (f_rd_retry !== 1'b1 || f_ack_valid !== 1'b1) begin
      failures++; $display("FAIL mrr_queued rd_retry=%b valid=%b exp=1/1", f_rd_retry, f_ack_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (f_ack_valid !== 1'b0 || f_ack_data !== 16'h0000 || f_wr_retry !== 1'b1 || f_rd_retry !== 1'b1) begin
      failures++; $display("FAIL mrr_async valid=%b data=%h wr_retry=%b rd_retry=%b exp=0/0000/1/1",
                           f_ack_valid, f_ack_data, f_wr_retry, f_rd_retry);
    end
    @(negedge clk);
    reset = 1'b0; ack_retry = 1'b0;
    for (int i = 0; i < Size; i++) begin
      if (!(f_rd_retry && f_wr_retry && o_rd_retry && !f_ack_valid)) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL mrr_init_retry bad_cycles=%0d exp=0", bad); end
    bad = 0;
    for (int i = 0; i <= Size; i++) begin
      if (i < Size) begin
        rd_valid = 1'b1; rd_addr = 8'(i);
        if (f_rd_retry !== 1'b0) bad++;
      end else begin
        rd_valid = 1'b0;
      end
      if (i > 0 && (f_ack_valid !== 1'b1 || f_ack_data !== 16'h0000 || o_ack_data !== 16'h0000)) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL mrr_all_zero bad=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_byte_enable();
    test_forwarding();
    test_backpressure();
    test_streaming();
    test_mid_run_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
